// File: rtl/votador_n_if.sv
// Voting bus between a vote source (master) and the votador_n tallier (slave).
// Carries session control, one vote per cycle, and the registered tally/result outputs.
interface votador_n_if #(
    parameter int N = 5
) ();
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic          close;
    logic          vote_valid;
    logic [IW-1:0] voter_id;
    logic          vote_yes;
    logic          busy;
    logic          done;
    logic          v;
    logic [CW-1:0] yes_cnt;
    logic [CW-1:0] no_cnt;
    logic          err;

    modport master (
        output start, close, vote_valid, voter_id, vote_yes,
        input  busy, done, v, yes_cnt, no_cnt, err
    );

    modport slave (
        input  start, close, vote_valid, voter_id, vote_yes,
        output busy, done, v, yes_cnt, no_cnt, err
    );
endinterface

// File: rtl/votador_n.sv
// N-voter tallier: one vote per cycle, each voter at most once; result latched until next start.
// Latency: counts/err/result one cycle after the sampling edge; no backpressure, every vote is accepted or rejected.
module votador_n #(
    parameter int N  = 5,
    parameter int TH = N / 2 + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    votador_n_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    localparam logic [IW:0]   N_ID  = N[IW:0];
    localparam logic [CW-1:0] N_CNT = N[CW-1:0];
    localparam logic [CW-1:0] TH_CNT = TH[CW-1:0];
    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  voted_q, voted_d;
    logic [CW-1:0] yes_q, yes_d;
    logic [CW-1:0] no_q, no_d;
    logic [CW-1:0] total_d;
    logic          v_q, v_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          id_ok;
    logic          already;

    // Out-of-range ids never index the flag vector.
    assign id_ok   = ({1'b0, bus.voter_id} < N_ID);
    assign already = id_ok ? voted_q[bus.voter_id] : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            voted_q <= '0;
            yes_q   <= '0;
            no_q    <= '0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            voted_q <= voted_d;
            yes_q   <= yes_d;
            no_q    <= no_d;
            v_q     <= v_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        voted_d = voted_q;
        yes_d   = yes_q;
        no_d    = no_q;
        v_d     = v_q;
        err_d   = 1'b0;
        total_d = yes_q + no_q;

        // start wins over close and any vote on the same cycle.
        if (bus.start) begin
            state_d = OPEN;
            voted_d = '0;
            yes_d   = '0;
            no_d    = '0;
            v_d     = 1'b0;
        end else begin
            case (state_q)
                OPEN: begin
                    if (bus.vote_valid) begin
                        if (id_ok && !already) begin
                            voted_d[bus.voter_id] = 1'b1;
                            if (bus.vote_yes) yes_d = yes_q + ONE;
                            else              no_d  = no_q + ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // Result uses the tally including a vote landing with close.
                    total_d = yes_d + no_d;
                    if (bus.close || (total_d == N_CNT)) begin
                        state_d = RESULT;
                        v_d     = (yes_d >= TH_CNT);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == OPEN);
        done_d = (state_d == RESULT);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.v       = v_q;
    assign bus.yes_cnt = yes_q;
    assign bus.no_cnt  = no_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_votador_n.sv
// Scoreboard bench for votador_n (N=5/TH=3 and N=3/TH=2 instances).
module tb_votador_n;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    votador_n_if #(.N(5)) b5 ();
    votador_n_if #(.N(3)) b3 ();

    votador_n #(.N(5), .TH(3)) dut5 (.clk(clk), .reset_n(reset_n), .bus(b5.slave));
    votador_n #(.N(3), .TH(2)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

    typedef struct {
        bit is_err;
        bit v;
        int yes;
        int no;
    } exp_t;

    exp_t q5[$];
    exp_t q3[$];
    int   tests = 0;
    int   fails = 0;
    bit   done5_prev = 1'b0;
    bit   done3_prev = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input bit is_err, input bit v, input int yes, input int no);
        exp_t e;
        e.is_err = is_err; e.v = v; e.yes = yes; e.no = no;
        return e;
    endfunction

    // Monitors: each err pulse and each rising done pops one expectation.
    always @(negedge clk) begin : mon5
        exp_t e;
        if (b5.err) begin
            if (q5.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon5_err: got unexpected err pulse, required none");
            end else begin
                e = q5.pop_front();
                chk("mon5_err_kind", 1, int'(e.is_err));
            end
        end
        if (b5.done && !done5_prev) begin
            if (q5.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon5_res: got unexpected result, required none");
            end else begin
                e = q5.pop_front();
                chk("mon5_res_kind", 0, int'(e.is_err));
                chk("mon5_v", int'(b5.v), int'(e.v));
                chk("mon5_yes", int'(b5.yes_cnt), e.yes);
                chk("mon5_no", int'(b5.no_cnt), e.no);
            end
        end
        done5_prev = b5.done;
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (b3.err) begin
            tests++; fails++;
            $display("FAIL mon3_err: got unexpected err pulse, required none");
        end
        if (b3.done && !done3_prev) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon3_res: got unexpected result, required none");
            end else begin
                e = q3.pop_front();
                chk("mon3_v", int'(b3.v), int'(e.v));
                chk("mon3_yes", int'(b3.yes_cnt), e.yes);
                chk("mon3_no", int'(b3.no_cnt), e.no);
            end
        end
        done3_prev = b3.done;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start5();
        b5.start = 1'b1; cyc(); b5.start = 1'b0;
    endtask

    task automatic close5();
        b5.close = 1'b1; cyc(); b5.close = 1'b0;
    endtask

    task automatic vote5(input int id, input bit y);
        b5.vote_valid = 1'b1; b5.voter_id = 3'(id); b5.vote_yes = y;
        cyc();
        b5.vote_valid = 1'b0;
    endtask

    task automatic vote3(input int id, input bit y);
        b3.vote_valid = 1'b1; b3.voter_id = 2'(id); b3.vote_yes = y;
        cyc();
        b3.vote_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit a, b, c;
        b5.start = 0; b5.close = 0; b5.vote_valid = 0; b5.voter_id = '0; b5.vote_yes = 0;
        b3.start = 0; b3.close = 0; b3.vote_valid = 0; b3.voter_id = '0; b3.vote_yes = 0;

        repeat (2) cyc();
        chk("rst_busy", int'(b5.busy), 0);
        chk("rst_done", int'(b5.done), 0);
        chk("rst_v", int'(b5.v), 0);
        chk("rst_err", int'(b5.err), 0);
        chk("rst_yes", int'(b5.yes_cnt), 0);
        chk("rst_no", int'(b5.no_cnt), 0);
        reset_n = 1'b1;
        cyc();

        vote5(0, 1);
        chk("idle_vote_yes", int'(b5.yes_cnt), 0);
        chk("idle_busy", int'(b5.busy), 0);

        // Full session, auto-close after 5th vote.
        start5();
        chk("t1_busy", int'(b5.busy), 1);
        chk("t1_done", int'(b5.done), 0);
        q5.push_back(mk(0, 1, 3, 2));
        vote5(0, 1); vote5(1, 1); vote5(2, 1);
        chk("t1_yes_mid", int'(b5.yes_cnt), 3);
        vote5(3, 0);
        chk("t1_v_open", int'(b5.v), 0);
        chk("t1_busy_4", int'(b5.busy), 1);
        vote5(4, 0);
        chk("t1_done_end", int'(b5.done), 1);
        chk("t1_busy_end", int'(b5.busy), 0);
        chk("t1_no_end", int'(b5.no_cnt), 2);

        // Duplicate and out-of-range votes.
        start5();
        vote5(2, 1);
        q5.push_back(mk(1, 0, 0, 0));
        vote5(2, 1);
        q5.push_back(mk(1, 0, 0, 0));
        vote5(7, 1);
        chk("t2_err", int'(b5.err), 1);
        chk("t2_yes", int'(b5.yes_cnt), 1);
        q5.push_back(mk(0, 0, 1, 0));
        close5();
        chk("t2_err_clear", int'(b5.err), 0);
        chk("t2_done", int'(b5.done), 1);
        chk("t2_v", int'(b5.v), 0);

        // Close coincides with an acceptable vote.
        start5();
        vote5(0, 1); vote5(1, 1);
        q5.push_back(mk(0, 1, 3, 0));
        b5.close = 1'b1;
        vote5(3, 1);
        b5.close = 1'b0;
        chk("t3_done", int'(b5.done), 1);
        chk("t3_v", int'(b5.v), 1);
        chk("t3_yes", int'(b5.yes_cnt), 3);

        // Vote in RESULT ignored, then restart.
        vote5(4, 1);
        chk("t5_yes_hold", int'(b5.yes_cnt), 3);
        chk("t5_done_hold", int'(b5.done), 1);
        chk("t5_err", int'(b5.err), 0);
        start5();
        chk("t5_busy", int'(b5.busy), 1);
        chk("t5_done", int'(b5.done), 0);
        chk("t5_v", int'(b5.v), 0);
        chk("t5_yes", int'(b5.yes_cnt), 0);
        chk("t5_no", int'(b5.no_cnt), 0);

        // start + close + vote together: start wins, vote dropped.
        vote5(0, 1);
        chk("tp_yes_pre", int'(b5.yes_cnt), 1);
        b5.start = 1'b1; b5.close = 1'b1;
        vote5(1, 1);
        b5.start = 1'b0; b5.close = 1'b0;
        chk("tp_busy", int'(b5.busy), 1);
        chk("tp_done", int'(b5.done), 0);
        chk("tp_yes", int'(b5.yes_cnt), 0);
        vote5(0, 0);
        chk("tp_no", int'(b5.no_cnt), 1);

        // Mid-session asynchronous reset.
        vote5(2, 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t4_busy", int'(b5.busy), 0);
        chk("t4_yes", int'(b5.yes_cnt), 0);
        chk("t4_no", int'(b5.no_cnt), 0);
        #4 reset_n = 1'b1;
        cyc();
        vote5(3, 1);
        chk("t4_ign_yes", int'(b5.yes_cnt), 0);
        chk("t4_ign_busy", int'(b5.busy), 0);
        chk("t4_ign_done", int'(b5.done), 0);
        start5();
        vote5(0, 1);
        chk("t4_resume_yes", int'(b5.yes_cnt), 1);
        q5.push_back(mk(0, 0, 1, 0));
        close5();
        chk("t4_done", int'(b5.done), 1);

        // 2-of-3 majority over all combinations.
        for (int k = 0; k < 8; k++) begin
            a = k[0]; b = k[1]; c = k[2];
            b3.start = 1'b1; cyc(); b3.start = 1'b0;
            q3.push_back(mk(0, (a & b) | (a & c) | (b & c),
                            int'(a) + int'(b) + int'(c),
                            3 - (int'(a) + int'(b) + int'(c))));
            vote3(0, a); vote3(1, b); vote3(2, c);
            chk("n3_done", int'(b3.done), 1);
        end

        repeat (2) cyc();
        chk("q5_left", q5.size(), 0);
        chk("q3_left", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
